seq_muldiv: RTL and testbench

Parametrised sequential unsigned multiply/divide unit for the accumulator CPU's MUL and DIV instructions. It replaces the fixed 16-bit repeated-subtraction divider with two radix-2 engines sharing one start/done handshake:
- a shift-add multiplier;
- a restoring divider.

Both engines have a fixed latency set by WIDTH. The controller raises start from its MUL/DIV states and waits in MULT_WAIT/DIV_WAIT until done.

---
 rtl/seq_muldiv_if.sv | 35 +++
 rtl/seq_muldiv.sv | 169 ++++++++++++++++
 tb/tb_seq_muldiv.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_muldiv_if.sv
// seq_muldiv_if
// Request/response bundle between the CPU controller and the sequential
// multiply/divide unit.
//   start  : request, sampled only while busy is low
//   op     : 0 = MUL, 1 = DIV, sampled with start
//   a, b   : multiplicand/dividend and multiplier/divisor, sampled with start
//   busy   : operation in flight
//   done   : single-cycle completion pulse
//   dz     : divide-by-zero flag, valid with done and held until the next done
//   res_lo : MUL product low half / DIV quotient
//   res_hi : MUL product high half / DIV remainder
// master = requester (controller), slave = the arithmetic unit.
interface seq_muldiv_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic             op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             dz;
    logic [WIDTH-1:0] res_lo;
    logic [WIDTH-1:0] res_hi;

    modport master (
        output start, op, a, b,
        input  busy, done, dz, res_lo, res_hi
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, dz, res_lo, res_hi
    );
endinterface

// File: rtl/seq_muldiv.sv
// seq_muldiv
// Sequential unsigned multiply/divide unit. One shared 2*WIDTH accumulator
// serves both a radix-2 shift-add multiplier and a radix-2 restoring divider.
// Every accepted operation takes exactly WIDTH cycles; divide-by-zero is
// answered one cycle after the request without entering RUN.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : seq_muldiv_if slave modport (start/op/a/b in, busy/done/dz/res out)
module seq_muldiv #(
    parameter int WIDTH = 16
) (
    input  logic         clk,
    input  logic         rst,
    seq_muldiv_if.slave  bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             state_r;
    logic               op_r;
    logic [CW-1:0]      cnt_r;
    logic [WIDTH-1:0]   opa_r;      // multiplicand, or dividend for a pending divide-by-zero
    logic [WIDTH-1:0]   opb_r;      // multiplier (shifts right) or divisor (static)
    logic [2*WIDTH-1:0] acc_r;      // MUL: partial product; DIV: {remainder, dividend/quotient}
    logic               dz_pend_r;
    logic               busy_r;
    logic               done_r;
    logic               dz_r;
    logic [WIDTH-1:0]   res_lo_r;
    logic [WIDTH-1:0]   res_hi_r;

    logic [WIDTH:0]     mul_add_s;
    logic [WIDTH:0]     mul_sum_s;
    logic [2*WIDTH-1:0] mul_next_s;
    logic [WIDTH:0]     div_trial_s;
    logic [2*WIDTH-1:0] div_next_s;
    logic [2*WIDTH-1:0] acc_next_s;
    logic [CW-1:0]      cnt_next_s;

    // One iteration of each engine, computed from the current accumulator.
    always_comb begin
        mul_add_s   = {(WIDTH+1){1'b0}};
        mul_sum_s   = {(WIDTH+1){1'b0}};
        mul_next_s  = {(2*WIDTH){1'b0}};
        div_trial_s = {(WIDTH+1){1'b0}};
        div_next_s  = {(2*WIDTH){1'b0}};
        acc_next_s  = {(2*WIDTH){1'b0}};
        cnt_next_s  = cnt_r - CNT_ONE;

        // Multiplier: add into the upper half keeping the carry, then the
        // carry becomes the new MSB as the accumulator shifts right.
        if (opb_r[0] == 1'b1) begin
            mul_add_s = {1'b0, opa_r};
        end else begin
            mul_add_s = {(WIDTH+1){1'b0}};
        end
        mul_sum_s  = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + mul_add_s;
        mul_next_s = {mul_sum_s, acc_r[WIDTH-1:1]};

        // Divider: the left-shifted remainder needs WIDTH+1 bits before the
        // trial subtraction; trial MSB set means a borrow (restore).
        div_trial_s = acc_r[2*WIDTH-1:WIDTH-1] - {1'b0, opb_r};
        if (div_trial_s[WIDTH] == 1'b0) begin
            div_next_s = {div_trial_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b1};
        end else begin
            div_next_s = {acc_r[2*WIDTH-2:0], 1'b0};
        end

        if (op_r == 1'b1) begin
            acc_next_s = div_next_s;
        end else begin
            acc_next_s = mul_next_s;
        end
    end

    // Controller, datapath registers and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= IDLE;
            op_r      <= 1'b0;
            cnt_r     <= CNT_ZERO;
            opa_r     <= {WIDTH{1'b0}};
            opb_r     <= {WIDTH{1'b0}};
            acc_r     <= {(2*WIDTH){1'b0}};
            dz_pend_r <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            dz_r      <= 1'b0;
            res_lo_r  <= {WIDTH{1'b0}};
            res_hi_r  <= {WIDTH{1'b0}};
        end else begin
            done_r    <= 1'b0;
            dz_pend_r <= 1'b0;

            // Divide-by-zero answer, one edge after the request was seen.
            if (dz_pend_r) begin
                done_r   <= 1'b1;
                dz_r     <= 1'b1;
                res_lo_r <= {WIDTH{1'b1}};
                res_hi_r <= opa_r;
            end else begin
                dz_r <= dz_r;
            end

            case (state_r)
                IDLE: begin
                    if (bus.start) begin
                        if (bus.op && (bus.b == {WIDTH{1'b0}})) begin
                            dz_pend_r <= 1'b1;
                            opa_r     <= bus.a;
                        end else begin
                            op_r    <= bus.op;
                            opa_r   <= bus.a;
                            opb_r   <= bus.b;
                            cnt_r   <= CNT_LOAD;
                            busy_r  <= 1'b1;
                            state_r <= RUN;
                            if (bus.op) begin
                                acc_r <= {{WIDTH{1'b0}}, bus.a};
                            end else begin
                                acc_r <= {(2*WIDTH){1'b0}};
                            end
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                RUN: begin
                    acc_r <= acc_next_s;
                    cnt_r <= cnt_next_s;
                    if (op_r == 1'b0) begin
                        opb_r <= {1'b0, opb_r[WIDTH-1:1]};
                    end else begin
                        opb_r <= opb_r;
                    end
                    if (cnt_next_s == CNT_ZERO) begin
                        busy_r   <= 1'b0;
                        done_r   <= 1'b1;
                        dz_r     <= 1'b0;
                        res_lo_r <= acc_next_s[WIDTH-1:0];
                        res_hi_r <= acc_next_s[2*WIDTH-1:WIDTH];
                        state_r  <= IDLE;
                    end else begin
                        state_r <= RUN;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                    cnt_r   <= CNT_ZERO;
                end
            endcase
        end
    end

    assign bus.busy   = busy_r;
    assign bus.done   = done_r;
    assign bus.dz     = dz_r;
    assign bus.res_lo = res_lo_r;
    assign bus.res_hi = res_hi_r;
endmodule

// File: tb/tb_seq_muldiv.sv
// tb_seq_muldiv
// Directed bench for seq_muldiv: a WIDTH=16 instance for most scenarios and a
// WIDTH=8 instance for the continuous-start back-to-back scenario.
module tb_seq_muldiv;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    seq_muldiv_if #(.WIDTH(16)) if16 ();
    seq_muldiv_if #(.WIDTH(8))  if8 ();

    seq_muldiv #(.WIDTH(16)) u_dut16 (.clk(clk), .rst(rst), .bus(if16));
    seq_muldiv #(.WIDTH(8))  u_dut8  (.clk(clk), .rst(rst), .bus(if8));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present a request at the falling edge; it is accepted at the next
    // rising edge (E0). Returns #1 after E0 with start already dropped.
    task automatic launch16(input logic op, input logic [15:0] a, input logic [15:0] b);
        @(negedge clk);
        if16.start = 1'b1;
        if16.op    = op;
        if16.a     = a;
        if16.b     = b;
        @(posedge clk);
        #1;
        if16.start = 1'b0;
    endtask

    // Watch 24 edges after E0. inj > 0 pulses a MUL 2x2 request before edge E(inj).
    task automatic collect16(input int inj, output int lat, output int busy_n,
                             output int done_n, output logic [15:0] lo,
                             output logic [15:0] hi, output logic dz);
        lat    = -1;
        busy_n = (if16.busy === 1'b1) ? 1 : 0;
        done_n = 0;
        lo     = 16'h0000;
        hi     = 16'h0000;
        dz     = 1'bx;
        for (int i = 1; i <= 24; i++) begin
            if (i == inj) begin
                if16.start = 1'b1;
                if16.op    = 1'b0;
                if16.a     = 16'd2;
                if16.b     = 16'd2;
            end else if (i == inj + 1) begin
                if16.start = 1'b0;
            end
            @(posedge clk);
            #1;
            if (if16.done === 1'b1) begin
                done_n++;
                if (lat < 0) begin
                    lat = i;
                    lo  = if16.res_lo;
                    hi  = if16.res_hi;
                    dz  = if16.dz;
                end
            end
            if (if16.busy === 1'b1 && lat < 0) busy_n++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({if16.busy, if16.done, if16.dz} !== 3'b000) begin
            $display("FAIL reset_flags16: got %b want 000", {if16.busy, if16.done, if16.dz});
            n_bad++;
        end
        n_cmp++;
        if ({if16.res_hi, if16.res_lo} !== 32'h0) begin
            $display("FAIL reset_res16: got %h want 0", {if16.res_hi, if16.res_lo});
            n_bad++;
        end
        n_cmp++;
        if ({if8.busy, if8.done, if8.dz, if8.res_hi, if8.res_lo} !== 19'h0) begin
            $display("FAIL reset_all8: got %h want 0", {if8.busy, if8.done, if8.dz, if8.res_hi, if8.res_lo});
            n_bad++;
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_div_basic();
        int lat, bn, dn;
        logic [15:0] lo, hi;
        logic dz;
        launch16(1'b1, 16'd25, 16'd7);
        collect16(0, lat, bn, dn, lo, hi, dz);
        n_cmp++;
        if (lat !== 16) begin $display("FAIL div25_7_latency: got %0d want 16", lat); n_bad++; end
        n_cmp++;
        if (bn !== 16) begin $display("FAIL div25_7_busy_cycles: got %0d want 16", bn); n_bad++; end
        n_cmp++;
        if ({hi, lo, dz} !== {16'd4, 16'd3, 1'b0}) begin
            $display("FAIL div25_7_result: got q=%0d r=%0d dz=%b want q=3 r=4 dz=0", lo, hi, dz); n_bad++;
        end
        n_cmp++;
        if (dn !== 1) begin $display("FAIL div25_7_done_pulses: got %0d want 1", dn); n_bad++; end
    endtask

    task automatic test_mul();
        int lat, bn, dn;
        logic [15:0] lo, hi;
        logic dz;
        launch16(1'b0, 16'hFFFF, 16'hFFFF);
        collect16(0, lat, bn, dn, lo, hi, dz);
        n_cmp++;
        if (lat !== 16) begin $display("FAIL mul_ffff_latency: got %0d want 16", lat); n_bad++; end
        n_cmp++;
        if ({hi, lo} !== 32'hFFFE_0001) begin
            $display("FAIL mul_ffff_result: got %h want fffe0001", {hi, lo}); n_bad++;
        end
        launch16(1'b0, 16'd15, 16'd17);
        collect16(0, lat, bn, dn, lo, hi, dz);
        n_cmp++;
        if ({hi, lo} !== 32'd255) begin $display("FAIL mul_15_17: got %h want 000000ff", {hi, lo}); n_bad++; end
    endtask

    task automatic test_div_zero();
        int lat, bn, dn;
        logic [15:0] lo, hi;
        logic dz;
        launch16(1'b1, 16'h1234, 16'h0000);
        collect16(0, lat, bn, dn, lo, hi, dz);
        n_cmp++;
        if (lat !== 1) begin $display("FAIL dz_latency: got %0d want 1", lat); n_bad++; end
        n_cmp++;
        if (bn !== 0) begin $display("FAIL dz_busy_cycles: got %0d want 0", bn); n_bad++; end
        n_cmp++;
        if ({dz, lo, hi} !== {1'b1, 16'hFFFF, 16'h1234}) begin
            $display("FAIL dz_result: got dz=%b lo=%h hi=%h want dz=1 lo=ffff hi=1234", dz, lo, hi); n_bad++;
        end
        n_cmp++;
        if (if16.dz !== 1'b1) begin $display("FAIL dz_held: got %b want 1", if16.dz); n_bad++; end
        launch16(1'b0, 16'd3, 16'd4);
        collect16(0, lat, bn, dn, lo, hi, dz);
        n_cmp++;
        if ({dz, hi, lo} !== {1'b0, 16'd0, 16'd12}) begin
            $display("FAIL mul_after_dz: got dz=%b hi=%0d lo=%0d want dz=0 hi=0 lo=12", dz, hi, lo); n_bad++;
        end
    endtask

    task automatic test_busy_ignore();
        int lat, bn, dn;
        logic [15:0] lo, hi;
        logic dz;
        launch16(1'b1, 16'd100, 16'd9);
        collect16(5, lat, bn, dn, lo, hi, dz);
        n_cmp++;
        if (lat !== 16) begin $display("FAIL ignore_latency: got %0d want 16", lat); n_bad++; end
        n_cmp++;
        if ({hi, lo} !== {16'd1, 16'd11}) begin
            $display("FAIL ignore_result: got q=%0d r=%0d want q=11 r=1", lo, hi); n_bad++;
        end
        n_cmp++;
        if (dn !== 1) begin $display("FAIL ignore_done_pulses: got %0d want 1", dn); n_bad++; end
    endtask

    task automatic test_reset_mid();
        int lat, bn, dn;
        int dn_rst;
        logic [15:0] lo, hi;
        logic dz;
        launch16(1'b1, 16'd1000, 16'd3);
        repeat (7) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({if16.busy, if16.done, if16.dz, if16.res_hi, if16.res_lo} !== 35'h0) begin
            $display("FAIL reset_mid_outputs: got busy=%b done=%b dz=%b hi=%h lo=%h want all 0",
                     if16.busy, if16.done, if16.dz, if16.res_hi, if16.res_lo); n_bad++;
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        dn_rst = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (if16.done === 1'b1) dn_rst++;
        end
        n_cmp++;
        if (dn_rst !== 0) begin $display("FAIL reset_mid_no_done: got %0d pulses want 0", dn_rst); n_bad++; end
        launch16(1'b1, 16'd1000, 16'd3);
        collect16(0, lat, bn, dn, lo, hi, dz);
        n_cmp++;
        if ({lat, hi, lo} !== {32'd16, 16'd1, 16'd333}) begin
            $display("FAIL div1000_3_after_reset: got lat=%0d q=%0d r=%0d want lat=16 q=333 r=1", lat, lo, hi); n_bad++;
        end
    endtask

    task automatic test_edge_cases();
        int lat, bn, dn;
        logic [15:0] lo, hi;
        logic dz;
        launch16(1'b0, 16'd0, 16'hBEEF);
        collect16(0, lat, bn, dn, lo, hi, dz);
        n_cmp++;
        if ({lat, hi, lo} !== {32'd16, 32'h0}) begin
            $display("FAIL mul_zero: got lat=%0d res=%h want lat=16 res=0", lat, {hi, lo}); n_bad++;
        end
        launch16(1'b1, 16'd5, 16'd9);
        collect16(0, lat, bn, dn, lo, hi, dz);
        n_cmp++;
        if ({lat, hi, lo} !== {32'd16, 16'd5, 16'd0}) begin
            $display("FAIL div_a_lt_b: got lat=%0d q=%0d r=%0d want lat=16 q=0 r=5", lat, lo, hi); n_bad++;
        end
    endtask

    task automatic test_back_to_back();
        int lat1, lat2;
        logic [7:0] lo1, hi1, lo2, hi2;
        logic busy_after, done_after;
        lat1 = -1; lat2 = -1;
        lo1 = 8'h00; hi1 = 8'h00; lo2 = 8'h00; hi2 = 8'h00;
        busy_after = 1'bx; done_after = 1'bx;
        @(negedge clk);
        if8.start = 1'b1;
        if8.op    = 1'b1;
        if8.a     = 8'd200;
        if8.b     = 8'd7;
        for (int i = 0; i <= 30; i++) begin
            @(posedge clk);
            #1;
            if (lat1 >= 0 && i == lat1 + 1) begin
                busy_after = if8.busy;
                done_after = if8.done;
            end
            if (if8.done === 1'b1) begin
                if (lat1 < 0) begin
                    lat1 = i;
                    lo1 = if8.res_lo;
                    hi1 = if8.res_hi;
                    if8.op = 1'b0;
                    if8.a  = 8'd13;
                    if8.b  = 8'd11;
                end else if (lat2 < 0) begin
                    lat2 = i;
                    lo2 = if8.res_lo;
                    hi2 = if8.res_hi;
                    if8.start = 1'b0;
                end
            end
        end
        if8.start = 1'b0;
        n_cmp++;
        if ({lat1, lo1, hi1} !== {32'd8, 8'd28, 8'd4}) begin
            $display("FAIL b2b_first: got lat=%0d q=%0d r=%0d want lat=8 q=28 r=4", lat1, lo1, hi1); n_bad++;
        end
        n_cmp++;
        if ({busy_after, done_after} !== 2'b10) begin
            $display("FAIL b2b_accept_edge: got busy=%b done=%b want busy=1 done=0", busy_after, done_after); n_bad++;
        end
        n_cmp++;
        if ({lat2, hi2, lo2} !== {32'd17, 8'd0, 8'd143}) begin
            $display("FAIL b2b_second: got lat=%0d hi=%0d lo=%0d want lat=17 hi=0 lo=143", lat2, hi2, lo2); n_bad++;
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        if16.start = 1'b0; if16.op = 1'b0; if16.a = 16'h0; if16.b = 16'h0;
        if8.start  = 1'b0; if8.op  = 1'b0; if8.a  = 8'h0;  if8.b  = 8'h0;
        test_reset();
        test_div_basic();
        test_mul();
        test_div_zero();
        test_busy_ignore();
        test_reset_mid();
        test_edge_cases();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
